// File: rtl/updown_seq_monitor_if.sv
// Monitor-side bundle: counter taps and control in, wrap/count/error status out.
interface updown_seq_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             d;
  logic [1:0]       q;
  logic             err_clr;
  logic             cnt_clr;
  logic             wrap_up;
  logic             wrap_down;
  logic [CNT_W-1:0] up_rev_cnt;
  logic [CNT_W-1:0] down_rev_cnt;
  logic             err;
  logic [1:0]       state_o;

  modport master (
    output d, q, err_clr, cnt_clr,
    input  wrap_up, wrap_down, up_rev_cnt, down_rev_cnt, err, state_o
  );

  modport slave (
    input  d, q, err_clr, cnt_clr,
    output wrap_up, wrap_down, up_rev_cnt, down_rev_cnt, err, state_o
  );
endinterface

// File: rtl/updown_seq_monitor.sv
// Checks each step of a 2-bit up/down counter against the direction registered
// on the previous edge; reports wraps, counts revolutions, latches the first error.
module updown_seq_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter bit          ALLOW_HOLD = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  updown_seq_monitor_if.slave bus
);

  localparam int unsigned Q_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_TRACK = 2'b01,
    S_ERROR = 2'b10
  } state_t;

  state_t           state;
  logic [Q_W-1:0]   q_prev;
  logic             d_prev;
  logic             wrap_up_r;
  logic             wrap_down_r;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] down_cnt;
  logic             err_r;

  logic [Q_W-1:0]   exp_q_c;
  logic             step_ok_c;
  logic             hold_ok_c;
  logic             up_wrap_c;
  logic             down_wrap_c;

  // q must equal q_prev stepped by the direction seen one edge earlier
  always_comb begin
    exp_q_c     = d_prev ? q_prev + Q_W'(1) : q_prev - Q_W'(1);
    step_ok_c   = (bus.q == exp_q_c);
    hold_ok_c   = ALLOW_HOLD && (bus.q == q_prev);
    up_wrap_c   = step_ok_c && d_prev && (q_prev == Q_W'(3));
    down_wrap_c = step_ok_c && !d_prev && (q_prev == Q_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      q_prev      <= '0;
      d_prev      <= 1'b0;
      wrap_up_r   <= 1'b0;
      wrap_down_r <= 1'b0;
      up_cnt      <= '0;
      down_cnt    <= '0;
      err_r       <= 1'b0;
    end else begin
      wrap_up_r   <= 1'b0;
      wrap_down_r <= 1'b0;
      if (bus.err_clr) err_r <= 1'b0;

      unique case (state)
        S_INIT: begin
          q_prev <= bus.q;
          d_prev <= bus.d;
          state  <= S_TRACK;
        end
        S_TRACK: begin
          if (step_ok_c) begin
            q_prev      <= bus.q;
            d_prev      <= bus.d;
            wrap_up_r   <= up_wrap_c;
            wrap_down_r <= down_wrap_c;
            if (up_wrap_c && up_cnt != CNT_MAX)
              up_cnt <= up_cnt + CNT_W'(1);
            if (down_wrap_c && down_cnt != CNT_MAX)
              down_cnt <= down_cnt + CNT_W'(1);
          end else if (hold_ok_c) begin
            d_prev <= bus.d;
          end else if (bus.err_clr) begin
            // clear coinciding with an illegal step wins: resync instead
            state <= S_INIT;
          end else begin
            err_r <= 1'b1;
            state <= S_ERROR;
          end
        end
        S_ERROR: begin
          if (bus.err_clr) state <= S_INIT;
        end
        default: state <= S_INIT;
      endcase

      // counter clear overrides any increment taken on the same edge
      if (bus.cnt_clr) begin
        up_cnt   <= '0;
        down_cnt <= '0;
      end
    end
  end

  assign bus.wrap_up      = wrap_up_r;
  assign bus.wrap_down    = wrap_down_r;
  assign bus.up_rev_cnt   = up_cnt;
  assign bus.down_rev_cnt = down_cnt;
  assign bus.err          = err_r;
  assign bus.state_o      = state;

endmodule
